// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side buses of mem_port_arbiter.
// The arbiter connects through the slave modport; the CPU/memory environment uses master.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // instruction-fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_done;
  logic [DW-1:0] if_rdata;

  // data (load/store) port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_done;
  logic [DW-1:0] d_rdata;

  // unified memory port
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ack;
  logic [DW-1:0] m_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  m_ack, m_rdata,
    output if_gnt, if_done, if_rdata,
    output d_gnt, d_done, d_rdata,
    output m_req, m_we, m_addr, m_wdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output m_ack, m_rdata,
    input  if_gnt, if_done, if_rdata,
    input  d_gnt, d_done, d_rdata,
    input  m_req, m_we, m_addr, m_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Folds the CPU fetch and data ports onto one variable-latency single-port memory.
// Optional macro MEM_ARB_STARVE_EN lets a waiting fetch win after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state_q,    state_d;
  logic          m_req_q,    m_req_d;
  logic          m_we_q,     m_we_d;
  logic [AW-1:0] m_addr_q,   m_addr_d;
  logic [DW-1:0] m_wdata_q,  m_wdata_d;
  logic          if_gnt_q,   if_gnt_d;
  logic          if_done_q,  if_done_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic          d_gnt_q,    d_gnt_d;
  logic          d_done_q,   d_done_d;
  logic [DW-1:0] d_rdata_q,  d_rdata_d;
  logic          busy_q,     busy_d;

  logic          starve_hit;
  logic          pick_i;

`ifdef MEM_ARB_STARVE_EN
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_hit = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

  // Counts data grants taken while a fetch was waiting; only IDLE decisions move it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == IDLE) begin
      if (!bus.if_req || pick_i) begin
        starve_cnt_d = '0;
      end else if (bus.d_req && !starve_hit) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  localparam int unused_starve_cfg = STARVE_LIMIT + CNT_W;

  assign starve_hit = 1'b0;
`endif

  // Data normally wins: it belongs to the older instruction.
  assign pick_i = bus.if_req && (!bus.d_req || starve_hit);

  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_gnt_d   = 1'b0;
    if_done_d  = 1'b0;
    d_gnt_d    = 1'b0;
    d_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          m_req_d = 1'b1;
          if (pick_i) begin
            state_d   = BUSY_I;
            if_gnt_d  = 1'b1;
            m_we_d    = 1'b0;
            m_addr_d  = bus.if_addr;
            m_wdata_d = '0;
          end else begin
            state_d   = BUSY_D;
            d_gnt_d   = 1'b1;
            m_we_d    = bus.d_we;
            m_addr_d  = bus.d_addr;
            m_wdata_d = bus.d_wdata;
          end
        end
      end

      BUSY_I: begin
        if (bus.m_ack) begin
          state_d    = IDLE;
          m_req_d    = 1'b0;
          m_we_d     = 1'b0;
          if_done_d  = 1'b1;
          if_rdata_d = bus.m_rdata;
        end
      end

      BUSY_D: begin
        if (bus.m_ack) begin
          state_d  = IDLE;
          m_req_d  = 1'b0;
          m_we_d   = 1'b0;
          d_done_d = 1'b1;
          // m_we_q still identifies the access being completed: stores leave d_rdata alone.
          if (!m_we_q) begin
            d_rdata_d = bus.m_rdata;
          end
        end
      end

      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
        m_we_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_gnt_q   <= 1'b0;
      if_done_q  <= 1'b0;
      if_rdata_q <= '0;
      d_gnt_q    <= 1'b0;
      d_done_q   <= 1'b0;
      d_rdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_gnt_q   <= if_gnt_d;
      if_done_q  <= if_done_d;
      if_rdata_q <= if_rdata_d;
      d_gnt_q    <= d_gnt_d;
      d_done_q   <= d_done_d;
      d_rdata_q  <= d_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.if_gnt   = if_gnt_q;
  assign bus.if_done  = if_done_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_gnt    = d_gnt_q;
  assign bus.d_done   = d_done_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.m_req    = m_req_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: autonomous requesters, a latency-programmable
// memory model and a per-port scoreboard, plus directed checks of reset and ordering.
module tb_mem_port_arbiter;
  localparam int AW           = 32;
  localparam int DW           = 32;
  localparam int STARVE_LIMIT = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  txn_t if_todo[$], d_todo[$], if_exp[$], d_exp[$];
  bit   gnt_log[$];  // 1 = data grant, 0 = fetch grant
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] d_rdata_model = '0;
  bit   if_active = 0, d_active = 0, cur_valid = 0, stray_ack = 0;
  int   mem_lat = 2, wait_cnt = 0, cyc = 0;
  int   if_gnt_n = 0, d_gnt_n = 0, if_done_n = 0, d_done_n = 0;
  int   last_gnt_cyc = -100, last_if_gnt_cyc = -100, last_d_gnt_cyc = -100, last_d_done_cyc = -100;
  int   if_done_lat = 0, if_gap = 0;
  txn_t cur, t, e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] read_model(input logic [31:0] addr);
    if (mem_model.exists(addr)) return mem_model[addr];
    return addr ^ 32'h5A5A_0000;
  endfunction

  // Requesters, memory and monitor all act on the falling edge.
  initial begin
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_ack = 0; bus.m_rdata = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        if_todo.delete(); d_todo.delete(); if_exp.delete(); d_exp.delete();
        if_active = 0; d_active = 0; cur_valid = 0; wait_cnt = 0;
        bus.if_req = 0; bus.d_req = 0;
        d_rdata_model = '0;
      end else begin
        if (bus.if_gnt | bus.d_gnt | bus.if_done | bus.d_done)
          check_eq("exclusive", 32'({bus.if_gnt & bus.d_gnt, bus.if_done & bus.d_done,
                                     bus.if_gnt & bus.if_done, bus.d_gnt & bus.d_done}), 32'd0);
        if (bus.if_gnt || bus.d_gnt) begin
          if (last_gnt_cyc >= 0) check_eq("gnt_spacing", 32'((cyc - last_gnt_cyc) >= 2), 32'd1);
          last_gnt_cyc = cyc;
        end
        if (bus.if_gnt) begin
          if_gnt_n++; gnt_log.push_back(1'b0);
          check_eq("if_gnt_pending", 32'(if_exp.size()), 32'd1);
          if (if_exp.size() > 0) begin
            cur = if_exp[0]; cur_valid = 1;
            check_eq("if_m_req", 32'(bus.m_req), 32'd1);
            check_eq("if_m_we", 32'(bus.m_we), 32'd0);
            check_eq("if_m_addr", bus.m_addr, cur.addr);
          end
          if_gap = cyc - last_d_done_cyc;
          last_if_gnt_cyc = cyc;
          void'(if_todo.pop_front());
          if_active = 0; bus.if_req = 0;
        end else if (bus.d_gnt) begin
          d_gnt_n++; gnt_log.push_back(1'b1);
          check_eq("d_gnt_pending", 32'(d_exp.size()), 32'd1);
          if (d_exp.size() > 0) begin
            cur = d_exp[0]; cur_valid = 1;
            check_eq("d_m_req", 32'(bus.m_req), 32'd1);
            check_eq("d_m_we", 32'(bus.m_we), 32'(cur.we));
            check_eq("d_m_addr", bus.m_addr, cur.addr);
            if (cur.we) check_eq("d_m_wdata", bus.m_wdata, cur.wdata);
          end
          last_d_gnt_cyc = cyc;
          void'(d_todo.pop_front());
          d_active = 0; bus.d_req = 0;
        end else if (bus.m_req && cur_valid) begin
          check_eq("m_addr_stable", bus.m_addr, cur.addr);
          check_eq("m_we_stable", 32'(bus.m_we), 32'(cur.we));
        end
        if (bus.if_done) begin
          if_done_n++;
          check_eq("if_done_expected", 32'(if_exp.size() > 0), 32'd1);
          if (if_exp.size() > 0) begin
            e = if_exp.pop_front();
            check_eq("if_rdata", bus.if_rdata, e.rdata);
            $display("txn I addr=%h rdata=%h cyc=%0d", e.addr, bus.if_rdata, cyc);
          end
          if_done_lat = cyc - last_if_gnt_cyc;
          cur_valid = 0;
        end
        if (bus.d_done) begin
          d_done_n++;
          check_eq("d_done_expected", 32'(d_exp.size() > 0), 32'd1);
          if (d_exp.size() > 0) begin
            e = d_exp.pop_front();
            if (!e.we) d_rdata_model = e.rdata;
            check_eq(e.we ? "d_rdata_after_store" : "d_rdata_load", bus.d_rdata, d_rdata_model);
            $display("txn D we=%0d addr=%h wdata=%h rdata=%h cyc=%0d",
                     e.we, e.addr, e.wdata, bus.d_rdata, cyc);
          end
          last_d_done_cyc = cyc;
          cur_valid = 0;
        end
      end

      // memory model
      if (bus.m_ack) begin
        bus.m_ack = 0;
      end else if (stray_ack) begin
        bus.m_ack = 1; bus.m_rdata = 32'hBAD0_0BAD; stray_ack = 0;
      end else if (bus.m_req && !reset) begin
        wait_cnt++;
        if (wait_cnt >= mem_lat) begin
          wait_cnt = 0; bus.m_ack = 1;
          if (bus.m_we) begin
            mem_model[bus.m_addr] = bus.m_wdata;
            bus.m_rdata = 32'h0BAD_57E5;
          end else begin
            bus.m_rdata = read_model(bus.m_addr);
          end
        end
      end else begin
        wait_cnt = 0;
      end

      // requesters: present the next queued transaction and book its expectation
      if (!reset) begin
        if (!if_active && if_todo.size() > 0) begin
          t = if_todo[0]; t.rdata = read_model(t.addr);
          if_exp.push_back(t);
          bus.if_req = 1; bus.if_addr = t.addr; if_active = 1;
        end
        if (!d_active && d_todo.size() > 0) begin
          t = d_todo[0]; t.rdata = t.we ? 32'h0 : read_model(t.addr);
          d_exp.push_back(t);
          bus.d_req = 1; bus.d_we = t.we; bus.d_addr = t.addr; bus.d_wdata = t.wdata; d_active = 1;
        end
      end
    end
  end

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((if_todo.size() + d_todo.size() + if_exp.size() + d_exp.size()) != 0 && n < budget) begin
      @(posedge clock); n++;
    end
    check_eq({tag, "_complete"}, 32'(n < budget), 32'd1);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"}, 32'({bus.if_gnt, bus.if_done, bus.d_gnt, bus.d_done,
                                  bus.m_req, bus.m_we, bus.busy}), 32'd0);
    check_eq({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
    check_eq({tag, "_d_rdata"}, bus.d_rdata, 32'd0);
    check_eq({tag, "_m_addr"}, bus.m_addr, 32'd0);
    check_eq({tag, "_m_wdata"}, bus.m_wdata, 32'd0);
  endtask

  initial begin
    int base, n, g0, d0, i0, nd, ni, cnt;
    bit exp_d;

    reset = 1;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 0;
    mem_model[32'h40] = 32'h2008_0005;

    // 1: fetch only, memory acks two cycles after m_req
    mem_lat = 2;
    if_todo.push_back('{1'b0, 32'h0000_0040, 32'h0, 32'h0});
    wait_idle("t1", 50);
    check_eq("t1_if_rdata", bus.if_rdata, 32'h2008_0005);
    check_eq("t1_if_gnt_count", 32'(if_gnt_n), 32'd1);
    check_eq("t1_if_done_count", 32'(if_done_n), 32'd1);
    check_eq("t1_done_latency", 32'(if_done_lat), 32'd2);
    check_eq("t1_busy", 32'(bus.busy), 32'd0);

    // 2: store only, then a load of it and a second store
    d_todo.push_back('{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0});
    wait_idle("t2", 50);
    check_eq("t2_d_done_count", 32'(d_done_n), 32'd1);
    check_eq("t2_d_rdata_unchanged", bus.d_rdata, 32'd0);
    check_eq("t2_if_rdata_held", bus.if_rdata, 32'h2008_0005);
    d_todo.push_back('{1'b0, 32'h0000_0100, 32'h0, 32'h0});
    d_todo.push_back('{1'b1, 32'h0000_0104, 32'h1234_5678, 32'h0});
    wait_idle("t2b", 100);
    check_eq("t2b_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);

    // 3: simultaneous requests, data first then fetch after one turnaround cycle
    base = gnt_log.size();
    if_todo.push_back('{1'b0, 32'h0000_0080, 32'h0, 32'h0});
    d_todo.push_back('{1'b0, 32'h0000_0200, 32'h0, 32'h0});
    wait_idle("t3", 100);
    check_eq("t3_grants", 32'(gnt_log.size() - base), 32'd2);
    if (gnt_log.size() >= base + 2) begin
      check_eq("t3_first_is_d", 32'(gnt_log[base]), 32'd1);
      check_eq("t3_second_is_i", 32'(gnt_log[base + 1]), 32'd0);
    end
    check_eq("t3_turnaround", 32'(if_gap), 32'd1);
    check_eq("t3_d_rdata", bus.d_rdata, 32'h5A5A_0200);

    // 4: reset while a store is outstanding, then a late ack
    mem_lat = 1000;
    g0 = d_gnt_n; d0 = d_done_n;
    d_todo.push_back('{1'b1, 32'h0000_0300, 32'hCAFE_F00D, 32'h0});
    n = 0;
    while (d_gnt_n == g0 && n < 20) begin @(posedge clock); n++; end
    #1;
    check_eq("t4_gnt_seen", 32'(n < 20), 32'd1);
    @(posedge clock); #1;
    check_eq("t4_busy_before", 32'(bus.busy), 32'd1);
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    check_all_zero("t4_after_reset");
    stray_ack = 1;
    mem_lat = 2;
    repeat (4) @(posedge clock);
    #1;
    check_eq("t4_no_d_done", 32'(d_done_n), 32'(d0));
    check_eq("t4_busy_idle", 32'(bus.busy), 32'd0);
    i0 = if_done_n;
    if_todo.push_back('{1'b0, 32'h0000_0044, 32'h0, 32'h0});
    wait_idle("t4_fetch", 50);
    check_eq("t4_fetch_done", 32'(if_done_n), 32'(i0 + 1));
    check_eq("t4_if_rdata", bus.if_rdata, 32'h5A5A_0044);

    // 6: ack while idle with no request
    g0 = if_gnt_n + d_gnt_n; d0 = if_done_n + d_done_n;
    stray_ack = 1;
    repeat (4) @(posedge clock);
    #1;
    check_eq("t6_no_gnt", 32'(if_gnt_n + d_gnt_n), 32'(g0));
    check_eq("t6_no_done", 32'(if_done_n + d_done_n), 32'(d0));
    check_eq("t6_busy", 32'(bus.busy), 32'd0);

    // 5: both ports requesting back to back
    mem_lat = 1;
    base = gnt_log.size();
    for (int k = 0; k < 10; k++) d_todo.push_back('{1'b0, 32'h400 + 32'(4 * k), 32'h0, 32'h0});
    for (int k = 0; k < 3; k++) if_todo.push_back('{1'b0, 32'h500 + 32'(4 * k), 32'h0, 32'h0});
    wait_idle("t5", 500);
    check_eq("t5_grants", 32'(gnt_log.size() - base), 32'd13);
    nd = 10; ni = 3; cnt = 0;
    for (int k = 0; k < 13; k++) begin
`ifdef MEM_ARB_STARVE_EN
      if (nd > 0 && ni > 0) begin
        if (cnt == STARVE_LIMIT) begin exp_d = 0; cnt = 0; end
        else begin exp_d = 1; cnt++; end
      end else begin
        exp_d = (nd > 0);
      end
`else
      exp_d = (nd > 0);
`endif
      if (exp_d) nd--; else ni--;
      if (gnt_log.size() > base + k)
        check_eq($sformatf("t5_order%0d", k), 32'(gnt_log[base + k]), 32'(exp_d));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
